// File: rtl/stream_demux_if.sv
// Stream demux bus: one input stream plus the shared output bus with per-output valid/ready.
// err_o is present only when STREAM_DEMUX_ERR_EN is defined.
interface stream_demux_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int OUTPUT_NUMBER = 8
);
   localparam int SEL_WIDTH = $clog2(OUTPUT_NUMBER);

   logic [SEL_WIDTH-1:0]     select_i;
   logic [DATA_WIDTH-1:0]    data_i;
   logic                     valid_i;
   logic                     last_i;
   logic                     ready_o;
   logic [DATA_WIDTH-1:0]    data_o;
   logic                     last_o;
   logic [OUTPUT_NUMBER-1:0] valid_o;
   logic [OUTPUT_NUMBER-1:0] ready_i;
`ifdef STREAM_DEMUX_ERR_EN
   logic                     err_o;

   modport master (
      output select_i, data_i, valid_i, last_i, ready_i,
      input  ready_o, data_o, last_o, valid_o, err_o
   );

   modport slave (
      input  select_i, data_i, valid_i, last_i, ready_i,
      output ready_o, data_o, last_o, valid_o, err_o
   );
`else
   modport master (
      output select_i, data_i, valid_i, last_i, ready_i,
      input  ready_o, data_o, last_o, valid_o
   );

   modport slave (
      input  select_i, data_i, valid_i, last_i, ready_i,
      output ready_o, data_o, last_o, valid_o
   );
`endif

endinterface

// File: rtl/stream_demux.sv
// Packet-aware stream demultiplexer with a one-entry output register slice.
// STREAM_DEMUX_ERR_EN: drop out-of-range packets and pulse err_o instead of clamping the select.
module stream_demux #(
   parameter int DATA_WIDTH    = 8,
   parameter int OUTPUT_NUMBER = 8
) (
   input logic           clk_i,
   input logic           rst_n_i,
   stream_demux_if.slave bus
);

   localparam int                   SEL_WIDTH = $clog2(OUTPUT_NUMBER);
   localparam logic [SEL_WIDTH:0]   NUM_OUT   = (SEL_WIDTH + 1)'(OUTPUT_NUMBER);
   localparam logic [SEL_WIDTH-1:0] LAST_OUT  = SEL_WIDTH'(OUTPUT_NUMBER - 1);

   typedef enum logic {IDLE, ROUTE} state_t;

   state_t                   state_q, state_d;
   logic [SEL_WIDTH-1:0]     dest_q, beat_dest, slice_dest_q;
   logic [DATA_WIDTH-1:0]    data_q;
   logic                     last_q, full_q;
   logic                     ready, accept, drain, load, sel_oor, beat_drop;
   logic [OUTPUT_NUMBER-1:0] valid;
`ifdef STREAM_DEMUX_ERR_EN
   logic                     drop_q, err_q;
`endif

   // First beat decides the destination; later beats reuse the latched one.
   always_comb begin
      sel_oor   = {1'b0, bus.select_i} >= NUM_OUT;
      beat_dest = dest_q;
`ifdef STREAM_DEMUX_ERR_EN
      beat_drop = drop_q;
`else
      beat_drop = 1'b0;
`endif
      if (state_q == IDLE) begin
`ifdef STREAM_DEMUX_ERR_EN
         beat_dest = bus.select_i;
         beat_drop = sel_oor;
`else
         beat_dest = sel_oor ? LAST_OUT : bus.select_i;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = bus.last_i ? IDLE : ROUTE;
      end
   end

   // Slice may refill on the same edge it drains, so ready follows the current destination's ready.
   assign ready  = rst_n_i && (!full_q || bus.ready_i[slice_dest_q]);
   assign drain  = full_q && bus.ready_i[slice_dest_q];
   assign accept = bus.valid_i && ready;
   assign load   = accept && !beat_drop;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dest_q <= '0;
`ifdef STREAM_DEMUX_ERR_EN
         drop_q <= 1'b0;
         err_q  <= 1'b0;
`endif
      end else begin
         if (accept && (state_q == IDLE)) begin
            dest_q <= beat_dest;
`ifdef STREAM_DEMUX_ERR_EN
            drop_q <= beat_drop;
`endif
         end
`ifdef STREAM_DEMUX_ERR_EN
         err_q <= accept && (state_q == IDLE) && beat_drop;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         full_q       <= 1'b0;
         data_q       <= '0;
         last_q       <= 1'b0;
         slice_dest_q <= '0;
      end else if (load) begin
         full_q       <= 1'b1;
         data_q       <= bus.data_i;
         last_q       <= bus.last_i;
         slice_dest_q <= beat_dest;
      end else if (drain) begin
         full_q <= 1'b0;
      end
   end

   always_comb begin
      valid = '0;
      if (full_q) begin
         valid[slice_dest_q] = 1'b1;
      end
   end

   assign bus.ready_o = ready;
   assign bus.data_o  = data_q;
   assign bus.last_o  = last_q;
   assign bus.valid_o = valid;
`ifdef STREAM_DEMUX_ERR_EN
   assign bus.err_o   = err_q;
`endif

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the width of each data beat in bits.
REQ-002 The block SHALL have parameter OUTPUT_NUMBER, default 8, the number of output ports (legal range 2..256).
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port select_i, input, $clog2(OUTPUT_NUMBER) bits, the destination index, sampled only on the first beat of a packet.
REQ-006 The block SHALL have port data_i, input, DATA_WIDTH bits, the input beat.
REQ-007 The block SHALL have port valid_i, input, 1 bit, which marks the input beat as valid.
REQ-008 The block SHALL have port last_i, input, 1 bit, which marks the final beat of a packet.
REQ-009 The block SHALL have port ready_o, output, 1 bit, which shows the block accepts the input beat.
REQ-010 The block SHALL have port data_o, output, DATA_WIDTH bits, a data bus shared by all outputs.
REQ-011 The block SHALL have port last_o, output, 1 bit, shared by all outputs, marking the final beat of a packet.
REQ-012 The block SHALL have port valid_o, output, OUTPUT_NUMBER bits, a one-hot per-output valid.
REQ-013 The block SHALL have port ready_i, input, OUTPUT_NUMBER bits, the per-output ready.
REQ-014 The block SHALL have port err_o, output, 1 bit, a one-cycle pulse on a dropped packet; it exists only when the macro in REQ-031 is defined.

Function
REQ-015 A beat SHALL transfer on the input when valid_i && ready_o are both high at a clock edge.
REQ-016 A beat SHALL transfer on output k when valid_o[k] && ready_i[k] are both high at a clock edge.
REQ-017 The FSM SHALL have two states: IDLE (waiting for the first beat of a packet) and ROUTE (a packet is in progress).
REQ-018 An input transfer in IDLE SHALL latch select_i as dest, apply that dest to this beat, and move the FSM to ROUTE; if last_i is also high, the FSM SHALL stay in IDLE.
REQ-019 In ROUTE, select_i SHALL be ignored and every beat SHALL use the latched dest.
REQ-020 An input transfer with last_i high in ROUTE SHALL return the FSM to IDLE.
REQ-021 Output SHALL be a one-entry register slice holding data, last and dest, with 1-cycle latency: a beat accepted at edge n drives valid_o[dest] from edge n onward.
REQ-022 ready_o SHALL equal !full || (ready_i[dest_reg]), so the block sustains one beat per cycle when the destination is ready.
REQ-023 When the slice drains and refills at the same edge, the slice SHALL load the new beat and valid SHALL stay high with no bubble.
REQ-024 At most one bit of valid_o SHALL be high at any time; the other bits SHALL be 0.
REQ-025 data_o and last_o SHALL hold their value while any valid_o bit is high and its ready is low.
REQ-026 valid_i SHALL be ignored when it is low, and no state SHALL change.
REQ-027 A packet at input SHALL NOT start before the previous packet's last beat has been accepted at input; packets to different outputs are therefore serialised in order.

Reset
REQ-028 Asserting rst_n_i SHALL immediately force the FSM to IDLE, the slice to empty, valid_o=0, data_o=0, last_o=0, err_o=0 and dest=0.
REQ-029 ready_o SHALL be 0 while in reset and 1 on the first cycle after release.
REQ-030 A reset during a packet SHALL discard the partial packet, and the next accepted beat SHALL be treated as a first beat.

Configuration
REQ-031 The block SHALL use macro STREAM_DEMUX_ERR_EN to select out-of-range handling.
REQ-032 With STREAM_DEMUX_ERR_EN defined, select_i >= OUTPUT_NUMBER on a first beat SHALL cause the whole packet to be accepted (ready_o=1) and dropped with no valid_o asserted. err_o SHALL pulse for 1 cycle on the first beat.
REQ-033 With STREAM_DEMUX_ERR_EN undefined, an out-of-range select SHALL be clamped to OUTPUT_NUMBER-1, and port err_o SHALL be absent.

Verification
REQ-034 Reset, then a 1-beat packet data=0x5A, last=1, select=3, with all ready high -> valid_o=0x08, data_o=0x5A, last_o=1 one cycle later, and the FSM is in IDLE.
REQ-035 A 4-beat packet with select=2 on beat 0 and select changed to 5 on beats 1-3 -> all 4 beats appear on output 2, back-to-back, at one beat per cycle.
REQ-036 ready_i[1] held low for 3 cycles with a 2-beat packet to output 1 -> data_o stays stable, ready_o=0 once the slice is full, and no beat is lost or duplicated.
REQ-037 Back-to-back packets to outputs 0 then 7 -> output 7's first beat follows output 0's last beat with no idle cycle.
REQ-038 OUTPUT_NUMBER=6 with select=7 -> with the macro, err_o pulses once and valid_o stays 0; without it, the beats appear on output 5.
REQ-039 Reset asserted mid-packet (beat 2 of 4) -> valid_o=0 at once; after release, a new packet with select=4 routes to output 4.
